// File: rtl/demo_de0_sys_st_arbiter.sv
// Packet-aware round-robin arbiter that merges NUM_IN Avalon-ST sources onto one sink.
// A source is granted only when it presents valid & sop while the arbiter is idle. It then
// owns the output until its eop beat is accepted, so packets never interleave.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   in_valid_i         per-source valid
//   in_data_i          per-source data, source i in [i*DATA_W +: DATA_W]
//   in_sop_i/in_eop_i  per-source packet framing
//   in_ready_o         per-source ready (only the granted source sees out_ready_i)
//   out_valid_o, out_data_o, out_sop_o, out_eop_o  merged stream
//   out_ready_i        sink backpressure
//   out_channel_o      granted source index in LOCK, else 0 (only with ST_ARB_CHANNEL_EN)
//   busy_o             high while a packet owns the output
//
// Optional feature macro: ST_ARB_CHANNEL_EN adds out_channel_o.
module demo_de0_sys_st_arbiter #(
   parameter int unsigned NUM_IN = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CH_W   = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [NUM_IN-1:0]        in_valid_i,
   input  logic [NUM_IN*DATA_W-1:0] in_data_i,
   input  logic [NUM_IN-1:0]        in_sop_i,
   input  logic [NUM_IN-1:0]        in_eop_i,
   output logic [NUM_IN-1:0]        in_ready_o,
   output logic                     out_valid_o,
   output logic [DATA_W-1:0]        out_data_o,
   output logic                     out_sop_o,
   output logic                     out_eop_o,
   input  logic                     out_ready_i,
`ifdef ST_ARB_CHANNEL_EN
   output logic [CH_W-1:0]          out_channel_o,
`endif
   output logic                     busy_o
);

   if (NUM_IN < 2 || NUM_IN > 8) begin : gen_bad_num_in
      $error("NUM_IN must be in the range 2..8");
   end
   if (CH_W != $clog2(NUM_IN)) begin : gen_bad_ch_w
      $error("CH_W must equal clog2(NUM_IN)");
   end

   typedef enum logic [0:0] {StIdle, StLock} state_e;

   state_e            state_q, state_d;
   logic [CH_W-1:0]   grant_q, grant_d;
   logic [CH_W-1:0]   last_grant_q, last_grant_d;
   logic              busy_q, busy_d;

   logic              lock;
   logic              sel_valid, sel_sop, sel_eop;
   logic [DATA_W-1:0] sel_data;
   logic              req_found;
   logic [CH_W-1:0]   req_pick;
   int unsigned       rank, best_rank;

   assign lock = (state_q == StLock);

   // Mux of the granted source's stream.
   always_comb begin
      sel_valid = 1'b0;
      sel_sop   = 1'b0;
      sel_eop   = 1'b0;
      sel_data  = '0;
      for (int unsigned c = 0; c < NUM_IN; c++) begin
         if (grant_q == CH_W'(c)) begin
            sel_valid = in_valid_i[c];
            sel_sop   = in_sop_i[c];
            sel_eop   = in_eop_i[c];
            sel_data  = in_data_i[c*DATA_W +: DATA_W];
         end
      end
   end

   // Round-robin pick: rank is the distance of source c past last_grant_q, so the source
   // right after the last winner ranks 0 and the last winner itself ranks NUM_IN-1.
   always_comb begin
      req_found = 1'b0;
      req_pick  = '0;
      best_rank = NUM_IN;
      rank      = 0;
      for (int unsigned c = 0; c < NUM_IN; c++) begin
         rank = (c + 2 * NUM_IN - 1 - 32'(last_grant_q)) % NUM_IN;
         if (in_valid_i[c] && in_sop_i[c] && (rank < best_rank)) begin
            best_rank = rank;
            req_pick  = CH_W'(c);
            req_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      unique case (state_q)
         StIdle: begin
            if (req_found) begin
               state_d = StLock;
               grant_d = req_pick;
            end
         end
         StLock: begin
            // Only an accepted eop beat releases the output.
            if (sel_valid && out_ready_i && sel_eop) begin
               state_d      = StIdle;
               last_grant_d = grant_q;
            end
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d == StLock);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         grant_q      <= '0;
         last_grant_q <= CH_W'(NUM_IN - 1);
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         busy_q       <= busy_d;
      end
   end

   always_comb begin
      in_ready_o = '0;
      for (int unsigned c = 0; c < NUM_IN; c++) begin
         in_ready_o[c] = lock && (grant_q == CH_W'(c)) && out_ready_i;
      end
   end

   assign out_valid_o = lock & sel_valid;
   assign out_sop_o   = lock & sel_sop;
   assign out_eop_o   = lock & sel_eop;
   assign out_data_o  = lock ? sel_data : '0;
   assign busy_o      = busy_q;

`ifdef ST_ARB_CHANNEL_EN
   assign out_channel_o = lock ? grant_q : '0;
`endif

endmodule

// File: tb/tb_demo_de0_sys_st_arbiter.sv
// Bench for demo_de0_sys_st_arbiter: per-source packet drivers, a transaction-level model
// that decides grants from the round-robin rule and queues the expected beats of each
// granted packet, and a monitor that pops the queue on every accepted output beat.
module tb_demo_de0_sys_st_arbiter;

   localparam int NUM_IN = 4;
   localparam int DATA_W = 32;
   localparam int CH_W   = 2;

   logic                     clk;
   logic                     rst_n;
   logic [NUM_IN-1:0]        in_valid;
   logic [NUM_IN*DATA_W-1:0] in_data;
   logic [NUM_IN-1:0]        in_sop;
   logic [NUM_IN-1:0]        in_eop;
   logic [NUM_IN-1:0]        in_ready;
   logic                     out_valid;
   logic [DATA_W-1:0]        out_data;
   logic                     out_sop;
   logic                     out_eop;
   logic                     out_ready;
   logic                     busy;
`ifdef ST_ARB_CHANNEL_EN
   logic [CH_W-1:0]          out_channel;
`endif

   demo_de0_sys_st_arbiter #(
      .NUM_IN (NUM_IN),
      .DATA_W (DATA_W),
      .CH_W   (CH_W)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .in_valid_i    (in_valid),
      .in_data_i     (in_data),
      .in_sop_i      (in_sop),
      .in_eop_i      (in_eop),
      .in_ready_o    (in_ready),
      .out_valid_o   (out_valid),
      .out_data_o    (out_data),
      .out_sop_o     (out_sop),
      .out_eop_o     (out_eop),
      .out_ready_i   (out_ready),
`ifdef ST_ARB_CHANNEL_EN
      .out_channel_o (out_channel),
`endif
      .busy_o        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              sop;
      logic              eop;
      int                ch;
   } beat_t;

   beat_t expq[$];
   int    vectors = 0;
   int    miscompares = 0;

   // Source drivers.
   bit                active [NUM_IN];
   bit                acc    [NUM_IN];
   int                len    [NUM_IN];
   int                bidx   [NUM_IN];
   logic [DATA_W-1:0] pd     [NUM_IN][4];
   bit                gen_en = 0;
   bit                bubble_en = 0;
   int                or_fixed = 1;

   // Reference model state.
   bit m_lock = 0;
   int m_owner = 0;
   int m_last = NUM_IN - 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic new_pkt(input int i, input int n, input logic [DATA_W-1:0] d0);
      active[i] = 1'b1;
      len[i]    = n;
      bidx[i]   = 0;
      for (int b = 0; b < 4; b++) pd[i][b] = d0 + DATA_W'(b);
   endtask

   task automatic drive();
      for (int i = 0; i < NUM_IN; i++) begin
         bit was_acc;
         was_acc = acc[i];
         acc[i]  = 1'b0;
         if (was_acc) begin
            bidx[i]++;
            if (bidx[i] == len[i]) active[i] = 1'b0;
         end
         if (!active[i] && gen_en && ($urandom_range(0, 3) == 0))
            new_pkt(i, int'($urandom_range(1, 4)), $urandom);
         if (active[i]) begin
            // A presented beat that was not taken stays valid and stable.
            if (!(in_valid[i] && !was_acc))
               in_valid[i] = bubble_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data[i*DATA_W +: DATA_W] = pd[i][bidx[i]];
            in_sop[i] = (bidx[i] == 0);
            in_eop[i] = (bidx[i] == len[i] - 1);
         end else begin
            in_valid[i] = 1'b0;
            in_sop[i]   = 1'b0;
            in_eop[i]   = 1'b0;
            in_data[i*DATA_W +: DATA_W] = $urandom;
         end
      end
      out_ready = (or_fixed < 0) ? ($urandom_range(0, 9) < 7) : or_fixed[0];
   endtask

   task automatic model_step();
      logic [NUM_IN-1:0] exp_ready;
      exp_ready = '0;
      if (m_lock && out_ready) exp_ready[m_owner] = 1'b1;
      chk("busy", 64'(busy), 64'(m_lock));
      chk("in_ready", 64'(in_ready), 64'(exp_ready));
      chk("out_valid", 64'(out_valid), 64'(m_lock ? in_valid[m_owner] : 1'b0));
`ifdef ST_ARB_CHANNEL_EN
      chk("out_channel", 64'(out_channel), 64'(m_lock ? m_owner : 0));
`endif
      for (int i = 0; i < NUM_IN; i++) acc[i] = in_valid[i] && exp_ready[i];
      if (!m_lock) begin
         // Search upward from last winner + 1, wrapping.
         for (int k = 1; k <= NUM_IN; k++) begin
            int c;
            c = (m_last + k) % NUM_IN;
            if (in_valid[c] && in_sop[c]) begin
               m_lock  = 1'b1;
               m_owner = c;
               for (int b = 0; b < len[c]; b++)
                  expq.push_back('{data: pd[c][b], sop: (b == 0), eop: (b == len[c] - 1), ch: c});
               break;
            end
         end
      end else if (acc[m_owner] && (bidx[m_owner] == len[m_owner] - 1)) begin
         m_lock = 1'b0;
         m_last = m_owner;
      end
   endtask

   task automatic cycle();
      drive();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit pending();
      bit p;
      p = m_lock;
      for (int i = 0; i < NUM_IN; i++) p = p | active[i];
      return p;
   endfunction

   task automatic drain();
      int n;
      gen_en = 0;
      n = 0;
      while (pending() && n < 400) begin
         cycle();
         n++;
      end
      if (pending()) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
      end
      cycle();
      chk("queue_empty", 64'(expq.size()), 64'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_sop_eop", 64'({out_sop, out_eop}), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
`ifdef ST_ARB_CHANNEL_EN
      chk("rst_out_channel", 64'(out_channel), 64'd0);
`endif
      for (int i = 0; i < NUM_IN; i++) begin
         active[i] = 1'b0;
         acc[i]    = 1'b0;
      end
      in_valid = '0;
      in_sop   = '0;
      in_eop   = '0;
      expq.delete();
      m_lock  = 1'b0;
      m_owner = 0;
      m_last  = NUM_IN - 1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted output beat must be the next expected one.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (expq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL beat_unexpected: got data %0h, required no beat", out_data);
         end else begin
            beat_t e;
            e = expq.pop_front();
            chk("beat", 64'({out_sop, out_eop, out_data}), 64'({e.sop, e.eop, e.data}));
`ifdef ST_ARB_CHANNEL_EN
            chk("beat_channel", 64'(out_channel), 64'(e.ch));
`endif
         end
      end
   end

   initial begin
      rst_n     = 1'b1;
      in_valid  = '0;
      in_sop    = '0;
      in_eop    = '0;
      in_data   = '0;
      out_ready = 1'b1;
      #3;

      // Source 0, 3-beat packet, sink always ready.
      do_reset();
      bubble_en = 0;
      or_fixed  = 1;
      new_pkt(0, 3, 32'h1000_0000);
      drain();

      // All four single-beat packets at once: strict round-robin from source 0.
      do_reset();
      for (int i = 0; i < NUM_IN; i++) new_pkt(i, 1, 32'hA0 + DATA_W'(i));
      drain();

      // Source 2 stalled mid-packet while source 1 waits.
      do_reset();
      new_pkt(2, 3, 32'h2200_0000);
      cycle();
      new_pkt(1, 2, 32'h1100_0000);
      or_fixed = 1; cycle();
      or_fixed = 0; cycle();
      or_fixed = 0; cycle();
      or_fixed = 1; cycle();
      drain();

      // Wrap-around: last_grant = NUM_IN-1 with sources 3 and 0 requesting.
      do_reset();
      new_pkt(3, 2, 32'h3300_0000);
      new_pkt(0, 1, 32'h0000_0001);
      drain();

      // Reset during the second beat of a 4-beat packet, then search restarts at 0.
      do_reset();
      new_pkt(0, 4, 32'h4400_0000);
      cycle();
      cycle();
      drive();
      do_reset();
      new_pkt(2, 1, 32'h5500_0002);
      new_pkt(0, 1, 32'h5500_0000);
      drain();

      // Randomised traffic with bubbles and backpressure.
      do_reset();
      gen_en    = 1;
      bubble_en = 1;
      or_fixed  = -1;
      repeat (3000) cycle();
      or_fixed = 1;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
